// File: rtl/combi_sweep_ctrl.sv
// combi_sweep_ctrl: walks a 4-input combinational block through all 16 input
// vectors and holds each vector for SETTLE_CYCLES clocks. It then samples Y
// into a truth-table signature and counts the bits that differ from a latched
// expected table.
// SETTLE_CYCLES must be in 1..255, because the wait counter is 8 bits wide.
module combi_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] expected,
    output logic [3:0]  abcd_out,
    input  logic        y_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] signature,
    output logic [4:0]  mismatch_count,
    output logic        pass
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  idx;
    logic [7:0]  wait_cnt;
    logic [15:0] exp_q;

    logic accept;
    logic last_wait;
    logic miss;

    assign accept    = (state == IDLE) && start && !abort;
    assign last_wait = (wait_cnt == 8'(SETTLE_CYCLES - 1));
    assign miss      = (y_in != exp_q[idx]);

    // State register.
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples pre-edge values and simulation ordering cannot matter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and state-derived outputs. abort wins over every other
    // transition out of SETTLE and SAMPLE.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        abcd_out   = 4'd0;
        case (state)
            IDLE: begin
                if (accept) state_next = SETTLE;
            end
            SETTLE: begin
                busy     = 1'b1;
                abcd_out = idx;
                if (abort)          state_next = IDLE;
                else if (last_wait) state_next = SAMPLE;
            end
            SAMPLE: begin
                busy     = 1'b1;
                abcd_out = idx;
                if (abort)             state_next = IDLE;
                else if (idx == 4'hF)  state_next = DONE;
                else                   state_next = SETTLE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Sweep datapath: index, settle counter, latched expected table and results.
    // NOTE: exp_q is a 16-bit register, not a memory array, so it is cheap to
    // reset with the rest of the state and always comes up at a known value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx            <= 4'd0;
            wait_cnt       <= 8'd0;
            exp_q          <= 16'd0;
            signature      <= 16'd0;
            mismatch_count <= 5'd0;
            pass           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        exp_q          <= expected;
                        signature      <= 16'd0;
                        mismatch_count <= 5'd0;
                        pass           <= 1'b0;
                        idx            <= 4'd0;
                        wait_cnt       <= 8'd0;
                    end
                end
                SETTLE: begin
                    if (abort || last_wait) begin
                        wait_cnt <= 8'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                SAMPLE: begin
                    // An aborting edge leaves the partial results untouched.
                    if (!abort) begin
                        signature[idx] <= y_in;
                        if (miss) mismatch_count <= mismatch_count + 5'd1;
                        if (idx == 4'hF) begin
                            // Fold in the final vector's miss so pass is
                            // already valid in the DONE cycle.
                            pass <= (mismatch_count == 5'd0) && !miss;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
